// File: rtl/bsram_sync_ctrl.sv
// bsram_sync_ctrl: syncs cartridge backup RAM with an SD save image, one sector per ack handshake
// Optional feature macro: BSRAM_AUTOSAVE_EN (track core writes, autosave when the OSD opens)
// Ports:
//   clk_i, reset_n_i                 system clock, async active-low reset
//   dl_active_i                      ROM download in progress
//   img_mounted_i/size_nz_i/ro_i     save-image mount strobe and its attributes
//   ram_mask_i[23:0]                 backup RAM byte mask; [23:9] is the last sector index
//   load_req_i, save_req_i           OSD load/save requests (levels)
//   osd_status_i, bsram_we_i         OSD open level, core backup-RAM write strobe
//   sd_ack_i                         sector transfer acknowledge
//   sd_rd_o, sd_wr_o, sd_lba_o[31:0] sector request and sector number
//   enable_o, loading_o, busy_o      backup RAM usable, load in progress, transfer active
//   done_o, dirty_o                  completion pulse, RAM modified since last sync
module bsram_sync_ctrl (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        dl_active_i,
  input  logic        img_mounted_i,
  input  logic        img_size_nz_i,
  input  logic        img_ro_i,
  input  logic [23:0] ram_mask_i,
  input  logic        load_req_i,
  input  logic        save_req_i,
  input  logic        osd_status_i,
  input  logic        bsram_we_i,
  input  logic        sd_ack_i,
  output logic        sd_rd_o,
  output logic        sd_wr_o,
  output logic [31:0] sd_lba_o,
  output logic        enable_o,
  output logic        loading_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        dirty_o
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;
  state_e state_q, state_d;
  logic [14:0] lba_q, lba_d;
  logic rd_q, rd_d, wr_q, wr_d, ena_q, ena_d, loading_q, loading_d;
  logic done_q, done_d, dirty_q, dirty_d;
  logic dl_q, ack_q, load_q, save_q;
  logic dl_rise, dl_fall, ack_rise, ack_fall, load_go, save_go, autosave_go, dirty_set;
  assign dl_rise  = dl_active_i & ~dl_q;
  assign dl_fall  = ~dl_active_i & dl_q;
  assign ack_rise = sd_ack_i & ~ack_q;
  assign ack_fall = ~sd_ack_i & ack_q;
  assign load_go  = load_req_i & ~load_q & ena_q;
  assign save_go  = save_req_i & ~save_q & ena_q;
`ifdef BSRAM_AUTOSAVE_EN
  logic osd_q;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) osd_q <= 1'b0;
    else osd_q <= osd_status_i;
  end
  assign autosave_go = osd_status_i & ~osd_q & ena_q & dirty_q;
  // writes made by a load are restoring the image, not modifying it
  assign dirty_set   = bsram_we_i & ~loading_q;
`else
  logic unused_inputs;
  assign unused_inputs = osd_status_i ^ bsram_we_i;
  assign autosave_go   = 1'b0;
  assign dirty_set     = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    done_d    = 1'b0;
    dirty_d   = dirty_q | dirty_set;
    ena_d     = dl_rise ? 1'b0 :
                (dl_active_i & img_mounted_i & img_size_nz_i & ~img_ro_i) ? |ram_mask_i : ena_q;
    if (state_q != IDLE && dl_rise) begin
      // a new download invalidates the RAM contents: drop the transfer silently
      state_d   = IDLE;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      loading_d = 1'b0;
    end else if (state_q == IDLE) begin
      if ((dl_fall & ena_q) | load_go) begin
        state_d   = REQ;
        lba_d     = '0;
        rd_d      = 1'b1;
        loading_d = 1'b1;
      end else if (save_go | autosave_go) begin
        state_d   = REQ;
        lba_d     = '0;
        wr_d      = 1'b1;
        loading_d = 1'b0;
      end
    end else if (state_q == REQ) begin
      if (ack_rise) begin
        state_d = XFER;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    end else if (ack_fall) begin
      if (lba_q >= ram_mask_i[23:9]) begin
        state_d   = IDLE;
        loading_d = 1'b0;
        done_d    = 1'b1;
        dirty_d   = 1'b0;
      end else begin
        state_d = REQ;
        lba_d   = lba_q + 15'd1;
        rd_d    = loading_q;
        wr_d    = ~loading_q;
      end
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ena_q     <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      dirty_q   <= 1'b0;
      dl_q      <= 1'b0;
      ack_q     <= 1'b0;
      load_q    <= 1'b0;
      save_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ena_q     <= ena_d;
      loading_q <= loading_d;
      done_q    <= done_d;
      dirty_q   <= dirty_d;
      dl_q      <= dl_active_i;
      ack_q     <= sd_ack_i;
      load_q    <= load_req_i;
      save_q    <= save_req_i;
    end
  end
  assign sd_rd_o   = rd_q;
  assign sd_wr_o   = wr_q;
  assign sd_lba_o  = {17'd0, lba_q};
  assign enable_o  = ena_q;
  assign loading_o = loading_q;
  assign busy_o    = state_q != IDLE;
  assign done_o    = done_q;
  assign dirty_o   = dirty_q;
endmodule

// File: tb/tb_bsram_sync_ctrl.sv
// tb_bsram_sync_ctrl: self-checking bench for bsram_sync_ctrl
module tb_bsram_sync_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic dl = 1'b0, mounted = 1'b0, size_nz = 1'b0, ro = 1'b0;
  logic [23:0] mask = '0;
  logic load_req = 1'b0, save_req = 1'b0, osd = 1'b0, we = 1'b0, ack = 1'b0;
  logic sd_rd, sd_wr, enable, loading, busy, done, dirty;
  logic [31:0] sd_lba;
  int checks = 0, failures = 0;
  int done_cnt = 0, rd_cyc = 0, wr_cyc = 0, overlap = 0, lba_hi = 0;
  int snap_done, snap_rd, snap_wr;

  typedef struct {
    logic        ro;
    logic        nz;
    logic [23:0] mask;
    logic        ena;
  } ena_vec_t;
  ena_vec_t tbl [5];

  always #5 clk = ~clk;

  bsram_sync_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n), .dl_active_i(dl), .img_mounted_i(mounted),
    .img_size_nz_i(size_nz), .img_ro_i(ro), .ram_mask_i(mask), .load_req_i(load_req),
    .save_req_i(save_req), .osd_status_i(osd), .bsram_we_i(we), .sd_ack_i(ack),
    .sd_rd_o(sd_rd), .sd_wr_o(sd_wr), .sd_lba_o(sd_lba), .enable_o(enable),
    .loading_o(loading), .busy_o(busy), .done_o(done), .dirty_o(dirty)
  );

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (sd_rd) rd_cyc <= rd_cyc + 1;
    if (sd_wr) wr_cyc <= wr_cyc + 1;
    if (sd_rd && sd_wr) overlap <= overlap + 1;
    if (sd_lba[31:15] != 17'd0) lba_hi <= lba_hi + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    snap_done = done_cnt;
    snap_rd   = rd_cyc;
    snap_wr   = wr_cyc;
  endtask

  task automatic pulse(input logic l, input logic s);
    load_req = l;
    save_req = s;
    step(1);
    load_req = 1'b0;
    save_req = 1'b0;
  endtask

  task automatic wait_req();
    int b;
    b = 0;
    while (!(sd_rd || sd_wr) && b < 50) begin
      step(1);
      b++;
    end
    if (b == 50) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: got no request expected sd_rd or sd_wr within 50 cycles");
    end
  endtask

  task automatic serve(input bit is_load, input int first, input int cnt);
    for (int s = first; s < first + cnt; s++) begin
      wait_req();
      chk("sd_rd", sd_rd, is_load);
      chk("sd_wr", sd_wr, !is_load);
      chk("sd_lba", sd_lba, s);
      ack = 1'b1;
      step($urandom_range(1, 3));
      ack = 1'b0;
      step($urandom_range(1, 3));
    end
  endtask

  task automatic expect_done(input bit is_load);
    step(2);
    chk("done_pulses", done_cnt - snap_done, 1);
    chk("busy_after_done", busy, 0);
    chk("loading_after_done", loading, 0);
    chk("dirty_after_done", dirty, 0);
    chk(is_load ? "wr_during_load" : "rd_during_save",
        is_load ? wr_cyc - snap_wr : rd_cyc - snap_rd, 0);
  endtask

  task automatic mount(input logic r, input logic z, input logic [23:0] m, input logic exp_ena);
    dl = 1'b1;
    step(1);
    ro = r;
    size_nz = z;
    mask = m;
    mounted = 1'b1;
    step(1);
    mounted = 1'b0;
    step(1);
    chk("mount_enable", enable, exp_ena);
    dl = 1'b0;
    step(1);
    chk("autoload_busy", busy, exp_ena);
    chk("autoload_loading", loading, exp_ena);
  endtask

  initial begin : main
    tbl[0] = '{1'b0, 1'b1, 24'h0007FF, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 24'h0007FF, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 24'h0007FF, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 24'h000000, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 24'h000100, 1'b1};

    #12;
    chk("reset_outs", {25'd0, sd_rd, sd_wr, enable, loading, busy, done, dirty}, 0);
    chk("reset_lba", sd_lba, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(2);
    chk("post_reset_busy", busy, 0);

    for (int i = 0; i < 5; i++) begin
      snap();
      mount(tbl[i].ro, tbl[i].nz, tbl[i].mask, tbl[i].ena);
      if (busy) begin
        dl = 1'b1;
        step(1);
        chk("abort_busy", busy, 0);
        chk("abort_enable", enable, 0);
        chk("abort_rd", sd_rd, 0);
        chk("abort_loading", loading, 0);
        dl = 1'b0;
        step(2);
        chk("abort_no_done", done_cnt - snap_done, 0);
      end
      pulse(1'b1, 1'b0);
      chk("load_when_disabled", busy, 0);
      step(1);
    end

    snap();
    mount(1'b0, 1'b1, 24'h001FFF, 1'b1);
    serve(1'b1, 0, 16);
    expect_done(1'b1);
    chk("enable_after_autoload", enable, 1);

    mask = 24'h0007FF;
    snap();
    pulse(1'b0, 1'b1);
    chk("save_busy", busy, 1);
    chk("save_loading", loading, 0);
    serve(1'b0, 0, 4);
    expect_done(1'b0);

    snap();
    pulse(1'b1, 1'b1);
    chk("collision_loading", loading, 1);
    serve(1'b1, 0, 2);
    pulse(1'b0, 1'b1);
    serve(1'b1, 2, 2);
    expect_done(1'b1);
    step(3);
    chk("dropped_save_busy", busy, 0);
    chk("dropped_save_wr", wr_cyc - snap_wr, 0);

`ifdef BSRAM_AUTOSAVE_EN
    we = 1'b1;
    step(1);
    we = 1'b0;
    step(1);
    chk("dirty_set", dirty, 1);
    snap();
    osd = 1'b1;
    step(1);
    osd = 1'b0;
    chk("autosave_busy", busy, 1);
    serve(1'b0, 0, 4);
    expect_done(1'b0);
`else
    we = 1'b1;
    step(1);
    we = 1'b0;
    step(1);
    chk("dirty_tied_low", dirty, 0);
    osd = 1'b1;
    step(1);
    osd = 1'b0;
    step(2);
    chk("no_autosave_busy", busy, 0);
    chk("no_autosave_wr", sd_wr, 0);
`endif

    for (int i = 0; i < 20; i++) begin
      int op, exp_n;
      bit is_load;
      logic [23:0] m;
      op = int'($urandom_range(0, 2));
      m = {15'($urandom_range(0, 7)), 9'($urandom_range(0, 511))};
      mask = m;
      exp_n = int'(m >> 9) + 1;
      is_load = (op != 1);
      snap();
      pulse(op != 1, op != 0);
      chk("rnd_busy", busy, 1);
      chk("rnd_loading", loading, is_load);
      serve(is_load, 0, exp_n);
      expect_done(is_load);
    end

    mask = 24'h0007FF;
    snap();
    pulse(1'b0, 1'b1);
    serve(1'b0, 0, 2);
    wait_req();
    chk("abort_at_lba", sd_lba, 2);
    chk("abort_pre_wr", sd_wr, 1);
    dl = 1'b1;
    step(1);
    chk("abort_save_wr", sd_wr, 0);
    chk("abort_save_busy", busy, 0);
    chk("abort_save_enable", enable, 0);
    step(2);
    chk("abort_save_no_done", done_cnt - snap_done, 0);
    dl = 1'b0;
    step(2);
    chk("no_autoload_when_disabled", busy, 0);

    mount(1'b0, 1'b1, 24'h0007FF, 1'b1);
    serve(1'b1, 0, 1);
    wait_req();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", {25'd0, sd_rd, sd_wr, enable, loading, busy, done, dirty}, 0);
    chk("async_reset_lba", sd_lba, 0);
    reset_n = 1'b1;
    step(2);
    chk("post_async_reset_busy", busy, 0);

    chk("rd_wr_overlap", overlap, 0);
    chk("lba_upper_zero", lba_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
